// File: rtl/pll_adc_lock_ctrl.sv
// rtl/pll_adc_lock_ctrl.sv - PLL lock supervisor and ADC capture reset sequencer
module pll_adc_lock_ctrl #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 240000,
  parameter int LOCK_STABLE_CYC  = 2400,
  parameter int MAX_RETRIES      = 7,
  parameter int CNT_W            = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       adc_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lol_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // Terminal counts: each state leaves on the edge where cnt equals its last value.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       retry, retry_n;
  logic [7:0]       lol, lol_n;
  logic             sync_q, locked_s;
  logic             attempt_fail;

  // Next-state logic; a failed lock attempt (timeout or drop during STABLE) is resolved once below.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    retry_n      = retry;
    lol_n        = lol;
    attempt_fail = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
        else                 cnt_n   = cnt + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (relock_req_i) begin
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end else if (locked_s) begin
          state_n = S_STABLE;
        end else if (cnt == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (relock_req_i) begin
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end else if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (cnt == STB_LAST) begin
          state_n = S_RUN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RUN: begin
        // Loss of lock takes precedence over a simultaneous software request.
        if (!locked_s) begin
          lol_n   = (lol == 8'hFF) ? lol : lol + 8'd1;
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end else if (relock_req_i) begin
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        if (relock_req_i) begin
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end
      end
      default: state_n = S_RESET_PLL;
    endcase
    if (attempt_fail) begin
      if (retry == RETRY_MAX) begin
        state_n = S_FAIL;
      end else begin
        retry_n = retry + 4'd1;
        state_n = S_RESET_PLL;
      end
    end
    if (state_n != state) cnt_n = '0;
  end

  // State, counters, lock synchroniser and outputs decoded from the next state so they are registered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry     <= 4'd0;
      lol       <= 8'd0;
      sync_q    <= 1'b0;
      locked_s  <= 1'b0;
      pll_rst_o <= 1'b1;
      adc_rst_o <= 1'b1;
      ready_o   <= 1'b0;
      fail_o    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      lol       <= lol_n;
      sync_q    <= pll_locked_i;
      locked_s  <= sync_q;
      pll_rst_o <= (state_n == S_RESET_PLL) || (state_n == S_FAIL);
      adc_rst_o <= (state_n != S_RUN);
      ready_o   <= (state_n == S_RUN);
      fail_o    <= (state_n == S_FAIL);
    end
  end

  assign retry_cnt_o = retry;
  assign lol_cnt_o   = lol;
  assign state_o     = state;

endmodule

// File: tb/tb_pll_adc_lock_ctrl.sv
// tb/tb_pll_adc_lock_ctrl.sv - self-checking bench for pll_adc_lock_ctrl
module tb_pll_adc_lock_ctrl;

  localparam int P = 4;
  localparam int T = 50;
  localparam int S = 10;
  localparam int R = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       relock_req_i = 1'b0;
  logic       pll_rst_o, adc_rst_o, ready_o, fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lol_cnt_o;
  logic [2:0] state_o;

  pll_adc_lock_ctrl #(
    .RST_PULSE_CYC(P), .LOCK_TIMEOUT_CYC(T), .LOCK_STABLE_CYC(S),
    .MAX_RETRIES(R), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked_i(pll_locked_i), .relock_req_i(relock_req_i),
    .pll_rst_o(pll_rst_o), .adc_rst_o(adc_rst_o), .ready_o(ready_o), .fail_o(fail_o),
    .retry_cnt_o(retry_cnt_o), .lol_cnt_o(lol_cnt_o), .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int n;
    bit r;
    bit lk;
    bit rq;
    int st;
    int rt;
    int lo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int n, bit r, bit lk, bit rq, int st, int rt, int lo);
    vec_t v;
    v = '{n, r, lk, rq, st, rt, lo};
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Outputs follow from the state by the spec's decode rules.
  task automatic check(string name, int st, int rt, int lo);
    bit ep, ea, er, ef;
    ep = (st == 0) || (st == 4);
    ea = (st != 3);
    er = (st == 3);
    ef = (st == 4);
    n_vec++;
    if (int'(state_o) != st || pll_rst_o !== ep || adc_rst_o !== ea || ready_o !== er ||
        fail_o !== ef || int'(retry_cnt_o) != rt || int'(lol_cnt_o) != lo || int'(retry_cnt_o) > R) begin
      n_bad++;
      $display("FAIL %s: got st=%0d prst=%0b arst=%0b rdy=%0b fail=%0b retry=%0d lol=%0d, want st=%0d prst=%0b arst=%0b rdy=%0b fail=%0b retry=%0d lol=%0d",
               name, state_o, pll_rst_o, adc_rst_o, ready_o, fail_o, retry_cnt_o, lol_cnt_o,
               st, ep, ea, er, ef, rt, lo);
    end
  endtask

  // Reference model: states by spec encoding, dwell measured as edges since entry,
  // synchroniser as a two-deep history of the raw lock input.
  int m_st, m_entry, m_rt, m_lo, m_cyc;
  bit h_new, h_old;

  task automatic model_edge(bit r, bit lk, bit rq);
    bit ls;
    int dur, nst;
    m_cyc++;
    if (r) begin
      m_st = 0; m_entry = m_cyc; m_rt = 0; m_lo = 0; h_new = 0; h_old = 0;
      return;
    end
    ls = h_old;
    h_old = h_new;
    h_new = lk;
    dur = m_cyc - m_entry;
    nst = m_st;
    case (m_st)
      0: if (dur == P) nst = 1;
      1: begin
        if (rq) begin m_rt = 0; nst = 0; end
        else if (ls) nst = 2;
        else if (dur == T) nst = -1;
      end
      2: begin
        if (rq) begin m_rt = 0; nst = 0; end
        else if (!ls) nst = -1;
        else if (dur == S) nst = 3;
      end
      3: begin
        if (!ls) begin m_lo = (m_lo < 255) ? m_lo + 1 : 255; m_rt = 0; nst = 0; end
        else if (rq) begin m_rt = 0; nst = 0; end
      end
      default: if (rq) begin m_rt = 0; nst = 0; end
    endcase
    if (nst == -1) begin
      if (m_rt == R) nst = 4;
      else begin m_rt++; nst = 0; end
    end
    if (nst != m_st) begin
      m_st = nst;
      m_entry = m_cyc;
    end
  endtask

  initial begin
    // n, rst, locked, relock -> state, retry, lol after the n-th edge
    add(2, 1, 1, 0, 0, 0, 0);   // reset values
    add(3, 0, 1, 0, 0, 0, 0);   // still pulsing PLL reset
    add(1, 0, 1, 0, 1, 0, 0);   // 4-cycle pulse done
    add(1, 0, 1, 0, 2, 0, 0);
    add(9, 0, 1, 0, 2, 0, 0);   // one cycle short of stable
    add(1, 0, 1, 0, 3, 0, 0);   // RUN at P+1+S edges after reset edge
    add(1, 0, 0, 0, 3, 0, 0);   // loss of lock enters synchroniser
    add(1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1);   // ready drops on third edge, lol=1
    add(4, 0, 1, 0, 1, 0, 1);
    add(1, 0, 1, 0, 2, 0, 1);
    add(5, 0, 1, 0, 2, 0, 1);
    add(1, 0, 0, 0, 2, 0, 1);   // one-cycle glitch in STABLE
    add(1, 0, 1, 0, 2, 0, 1);
    add(1, 0, 1, 0, 0, 1, 1);   // glitch seen -> retry=1
    add(4, 0, 1, 0, 1, 1, 1);
    add(11, 0, 1, 0, 3, 1, 1);
    add(1, 0, 1, 1, 0, 0, 1);   // software relock in RUN: lol unchanged
    add(15, 0, 1, 0, 3, 0, 1);
    add(1, 0, 0, 0, 3, 0, 1);
    add(1, 0, 0, 0, 3, 0, 1);
    add(1, 0, 0, 1, 0, 0, 2);   // loss + relock same cycle: lol increments
    add(53, 0, 0, 0, 1, 0, 2);  // timeout path, locked held low
    add(1, 0, 0, 0, 0, 1, 2);   // first timeout
    add(54, 0, 0, 0, 0, 2, 2);  // pulses 54 cycles apart
    add(54, 0, 0, 0, 4, 2, 2);  // retries exhausted -> FAIL
    add(20, 0, 0, 0, 4, 2, 2);  // FAIL held
    add(1, 0, 1, 1, 0, 0, 2);   // relock clears fail
    add(15, 0, 1, 0, 3, 0, 2);
    add(3, 0, 0, 0, 0, 0, 3);
    add(54, 0, 0, 0, 0, 1, 3);
    add(4, 0, 0, 0, 1, 1, 3);   // WAIT_LOCK with retry=1, lol=3
    add(1, 1, 0, 0, 0, 0, 0);   // mid-sequence reset
    add(2, 0, 1, 1, 0, 0, 0);   // relock ignored in RESET_PLL
    add(2, 0, 1, 0, 1, 0, 0);
    add(11, 0, 1, 0, 3, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      pll_locked_i = tbl[i].lk;
      relock_req_i = tbl[i].rq;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].rt, tbl[i].lo);
    end
    relock_req_i = 1'b0;

    // Repeated loss of lock from RUN: 3-cycle ready drop, lol saturates at 255.
    for (int i = 0; i < 260; i++) begin
      int k, w;
      pll_locked_i = 1'b0;
      k = 0;
      while (k < 10) begin
        tick();
        k++;
        if (ready_o === 1'b0) break;
      end
      n_vec++;
      if (k != 3 || int'(lol_cnt_o) != ((i + 1 < 255) ? i + 1 : 255)) begin
        n_bad++;
        $display("FAIL lol_iter%0d: got drop_cycles=%0d lol=%0d, want drop_cycles=3 lol=%0d",
                 i, k, lol_cnt_o, (i + 1 < 255) ? i + 1 : 255);
      end
      pll_locked_i = 1'b1;
      w = 0;
      while (w < 40 && ready_o !== 1'b1) begin
        tick();
        w++;
      end
      if (ready_o !== 1'b1) begin
        n_vec++;
        n_bad++;
        $display("FAIL relock_timeout%0d: got ready=%0b, want ready=1 within 40 cycles", i, ready_o);
        break;
      end
    end
    check("lol_saturated", 3, 0, 255);

    // Randomized run against the reference model.
    m_cyc = 0;
    begin
      bit lk;
      lk = 1'b1;
      for (int c = 0; c < 15000; c++) begin
        bit r, rq;
        r = (c < 2) || ($urandom_range(0, 3999) == 0);
        if (lk) lk = ($urandom_range(0, 399) != 0);
        else    lk = ($urandom_range(0, 39) == 0);
        rq = ($urandom_range(0, 299) == 0);
        rst = r;
        pll_locked_i = lk;
        relock_req_i = rq;
        @(posedge refclk);
        model_edge(r, lk, rq);
        #1;
        check($sformatf("rand%0d", c), m_st, m_rt, m_lo);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
